// File: rtl/knight_anim_pkg.sv
// knight_anim_pkg: shared sprite-ROM layout and status encoding for the knight animation.
package knight_anim_pkg;
    typedef enum logic [1:0] {IDLE, WALK, JUMP, FALL} status_t;

    // Index 0 is the rightmost element: idle, walk, jump-up, fall.
    localparam logic [3:0][3:0] BASE  = {4'd13, 4'd10, 4'd4, 4'd0};
    localparam logic [3:0][2:0] LEN   = {3'd3, 3'd3, 3'd6, 3'd4};
    localparam logic [3:0]      LOOPS = 4'b0011;

    localparam int FRAME_W = 32;
    localparam int FRAME_H = 64;
    localparam logic [9:0] X_CENTER = 10'd320;

    function automatic status_t map_status(input logic [3:0] s);
        return (s > 4'd3) ? IDLE : status_t'(s[1:0]);
    endfunction
endpackage

// File: rtl/knight_sprite_anim_sequencer.sv
// anim_sequencer: per-status frame sequencing with a frame-rate divider.
module anim_sequencer
    import knight_anim_pkg::*;
#(
    parameter int ANIM_DIV = 6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [3:0] Player_Status,
    output logic [3:0] anim_frame
);
    localparam logic [5:0] DIV_LAST = 6'(ANIM_DIV - 1);

    status_t    cur_status;
    status_t    next_status;
    logic [5:0] div_cnt;
    logic [2:0] frame_idx;
    logic [2:0] last_idx;

    assign next_status = map_status(Player_Status);
    assign last_idx    = LEN[cur_status] - 3'd1;
    assign anim_frame  = BASE[cur_status] + {1'b0, frame_idx};

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cur_status <= IDLE;
            div_cnt    <= '0;
            frame_idx  <= '0;
        end else if (next_status != cur_status) begin
            cur_status <= next_status;
            div_cnt    <= '0;
            frame_idx  <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            // Looping sequences wrap to 0; one-shots park on their last frame.
            frame_idx <= (frame_idx != last_idx) ? frame_idx + 3'd1 :
                         LOOPS[cur_status] ? 3'd0 : frame_idx;
        end else begin
            div_cnt <= div_cnt + 6'd1;
        end
    end
endmodule

// File: rtl/knight_sprite_anim.sv
// knight_sprite_anim: knight animation state, facing direction and per-pixel sprite-ROM addressing.
module knight_sprite_anim
    import knight_anim_pkg::*;
#(
    parameter int ANIM_DIV = 6,
    parameter int ADDR_W   = 15
) (
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic [9:0]        Player_Size_X,
    input  logic [9:0]        Player_Size_Y,
    input  logic [3:0]        Player_Status,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [3:0]        anim_frame,
    output logic              facing_left,
    output logic              is_knight,
    output logic [ADDR_W-1:0] sprite_addr
);
    logic [9:0]        prev_x;
    logic signed [10:0] left;
    logic signed [10:0] top;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [9:0]        col;
    logic [9:0]        row;

    anim_sequencer #(.ANIM_DIV(ANIM_DIV)) u_seq (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .Player_Status(Player_Status),
        .anim_frame   (anim_frame)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_x      <= X_CENTER;
            facing_left <= 1'b0;
        end else begin
            prev_x <= PlayerX;
            if (PlayerX < prev_x)
                facing_left <= 1'b1;
            else if (PlayerX > prev_x)
                facing_left <= 1'b0;
        end
    end

    // Signed offsets keep the box test correct when the knight overhangs the screen edge.
    assign left = $signed({1'b0, PlayerX}) - $signed({2'b0, Player_Size_X[9:1]});
    assign top  = $signed({1'b0, PlayerY}) - $signed({2'b0, Player_Size_Y[9:1]});
    assign dx   = $signed({1'b0, DrawX}) - left;
    assign dy   = $signed({1'b0, DrawY}) - top;

    assign is_knight = !dx[10] && !dy[10] &&
                       (dx < $signed({1'b0, Player_Size_X})) &&
                       (dy < $signed({1'b0, Player_Size_Y}));

    assign col = facing_left ? Player_Size_X - 10'd1 - dx[9:0] : dx[9:0];
    assign row = dy[9:0];

    assign sprite_addr = is_knight ?
        ADDR_W'({28'd0, anim_frame} * FRAME_W * FRAME_H + {22'd0, row} * FRAME_W + {22'd0, col}) :
        '0;
endmodule

// File: doc/knight_sprite_anim.md
Name: knight_sprite_anim

Overview:
- Consumer on the far side of the player-motion interface: takes PlayerX/PlayerY/Player_Size_X/Player_Size_Y/Player_Status each frame.
- Maintains the knight's animation state: per-status frame sequencing, frame-rate divider and facing direction.
- Answers the VGA colour mapper's per-pixel query with a hit flag and a sprite-ROM address, mirrored when facing left.
- Sits between the player-motion block and the sprite ROM / colour mapper.

Parameters:
- ANIM_DIV, 6: frame_clk ticks per animation frame (legal range 1..63).
- FRAME_W, 32: ROM row stride in pixels per sprite frame (power of two, at least Player_Size_X).
- FRAME_H, 64: rows per sprite frame (at least Player_Size_Y).
- ADDR_W, 15: sprite_addr width; 16 frames × FRAME_W × FRAME_H = 32768 words.

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  clock, one rising edge per video frame (vsync)
- PlayerX  in  10  knight centre X
- PlayerY  in  10  knight centre Y
- Player_Size_X  in  10  knight width (30 in the current game)
- Player_Size_Y  in  10  knight height (62 in the current game)
- Player_Status  in  4  0 idle, 1 walk, 2 jump-up, 3 fall; values 4–15 are treated as idle
- DrawX  in  10  current pixel X from the VGA controller
- DrawY  in  10  current pixel Y from the VGA controller
- anim_frame  out  4  absolute ROM frame index 0..15
- facing_left  out  1  1 = sprite is mirrored horizontally
- is_knight  out  1  current pixel lies inside the knight box
- sprite_addr  out  ADDR_W  ROM word address for the current pixel

Behaviour:
- Reset: the Reset/frame_clk pair is asynchronous, active-high. On reset: cur_status=0, frame_idx=0, div_cnt=0, facing_left=0, prev_x=PlayerX_Center constant 320, anim_frame=0.
- ROM layout, held in shared constants:
  - idle: base 0, length 4, loops
  - walk: base 4, length 6, loops
  - jump-up: base 10, length 3, one-shot
  - fall: base 13, length 3, one-shot
- Registered state updates on every rising edge of frame_clk, in this priority order:
  1. Status change (Player_Status mapped ≠ cur_status): cur_status ← new status; frame_idx ← 0; div_cnt ← 0.
  2. Otherwise, if div_cnt == ANIM_DIV-1: div_cnt ← 0.
     - Loop class: frame_idx ← (frame_idx == len-1) ? 0 : frame_idx+1.
     - One-shot class: frame_idx saturates at len-1.
  3. Otherwise: div_cnt ← div_cnt+1.
  - Result: anim_frame = base(cur_status) + frame_idx, registered, so it lags the input status by exactly 1 frame_clk.
- Facing, updated every edge:
  - PlayerX < prev_x → facing_left ← 1.
  - PlayerX > prev_x → facing_left ← 0.
  - Equal → hold.
  - prev_x ← PlayerX on every edge.
- Pixel query, combinational from DrawX/DrawY and the registered state. Use 11-bit signed intermediates so no underflow occurs at the screen edge.
  - left = PlayerX − Player_Size_X/2 (integer divide); top = PlayerY − Player_Size_Y/2.
  - is_knight = 1 iff left ≤ DrawX < left+Player_Size_X and top ≤ DrawY < top+Player_Size_Y. The right and bottom edges are exclusive.
  - col = DrawX − left; row = DrawY − top.
  - If facing_left, col ← Player_Size_X−1−col.
  - sprite_addr = anim_frame·FRAME_W·FRAME_H + row·FRAME_W + col, truncated to ADDR_W.
  - When is_knight=0, sprite_addr = 0.
- Simultaneous status change and divider terminal count: the status change wins and the frame restarts at 0.
- Reset asserted mid-animation: all state returns to reset values immediately, with no dependence on the clock.
- Player_Status values above 3 map to idle before comparison, so toggling between 0 and 7 does not restart the animation.

Decomposition:
- Package knight_anim_pkg holds:
  - the status enum (IDLE, WALK, JUMP, FALL)
  - per-status BASE and LEN constant arrays
  - the loop/one-shot flag per status
  - FRAME_W and FRAME_H
- One sub-module, anim_sequencer: owns cur_status, div_cnt and frame_idx, and outputs anim_frame.
- The top level keeps the facing register and the combinational pixel-address logic.

Test Plan:
- Reset, then idle with ANIM_DIV=4 → anim_frame reads 0, then 1 after 4 edges, 3 after 12 edges, wraps to 0 after 16 edges.
- Idle at frame 2, then Status=1 → next edge anim_frame=4. Continued walk reaches 9 after 20 edges and then wraps to 4.
- Status=2 held for 40 edges → anim_frame steps 10, 11, 12, then stays at 12. Switching to Status=3 → 13 on the next edge.
- PlayerX=320, PlayerY=377, sizes 30/62, facing right, anim_frame=0:
  - DrawX=305, DrawY=346 → is_knight=1, sprite_addr=0.
  - DrawX=335 → is_knight=0, sprite_addr=0.
  - DrawX=334, DrawY=407 → is_knight=1, addr=61·32+29=1981.
- PlayerX 320→318 → facing_left=1. DrawX=303, DrawY=346 → col mirrored to 29, addr=29. PlayerX held at 318 → facing_left stays 1.
- Reset asserted between clock edges during walk frame 7 → anim_frame=0 and facing_left=0 immediately. Status=3 while div_cnt=ANIM_DIV-1 → anim_frame=13 on the next edge.
